// File: rtl/ha_array_reducer.sv
// Consumer end of the 8x8 approximate-multiplier half-adder array.
// It captures four (t, b) array pairs and folds them into one product over four cycles.
module ha_array_reducer #(
    parameter bit SATURATE = 1'b1,
    parameter int OUT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       ha_array_0_t,
    input  logic [8:0]       ha_array_1_t,
    input  logic [8:0]       ha_array_2_t,
    input  logic [8:0]       ha_array_3_t,
    input  logic [6:0]       ha_array_0_b,
    input  logic [6:0]       ha_array_1_b,
    input  logic [6:0]       ha_array_2_b,
    input  logic [6:0]       ha_array_3_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product,
    output logic             ovf
);

    localparam int ACC_W = 18;             // holds 86615 without wrapping
    localparam int EXT_W = ACC_W + OUT_W;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       count_q, count_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [3:0][8:0]  t_q, t_d;
    logic [3:0][6:0]  b_q, b_d;
    logic [OUT_W-1:0] product_q, product_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [9:0]       v_sel;
    logic [ACC_W-1:0] contrib;
    logic [ACC_W-1:0] sum;
    logic [EXT_W-1:0] sum_ext;
    logic             sum_ovf;
    logic [OUT_W-1:0] sum_final;

    assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    // Array value t + 4*b, then shifted to its weight 4^count in the product.
    assign v_sel   = 10'(t_q[count_q]) + {1'b0, b_q[count_q], 2'b00};
    assign contrib = {8'd0, v_sel} << {count_q, 1'b0};
    assign sum     = acc_q + contrib;

    assign sum_ext   = EXT_W'(sum);
    assign sum_ovf   = |sum_ext[EXT_W-1:OUT_W];
    assign sum_final = (SATURATE && sum_ovf) ? '1 : sum_ext[OUT_W-1:0];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        t_d       = t_q;
        b_d       = b_q;
        product_d = product_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE: begin
                if (accept) state_d = ACC;
            end
            ACC: begin
                acc_d   = sum;
                count_d = count_q + 2'd1;
                if (count_q == 2'd3) begin
                    product_d = sum_final;
                    ovf_d     = sum_ovf;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = accept ? ACC : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A pop in DONE restarts accumulation in the same cycle as the hand-off.
        if (accept) begin
            t_d     = {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};
            b_d     = {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};
            acc_d   = '0;
            count_d = 2'd0;
        end
    end

    // NOTE: state updates use <= so every register samples pre-edge values; = here would race.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= 2'd0;
            acc_q     <= '0;
            t_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            t_q       <= t_d;
            b_q       <= b_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign product   = product_q;
    assign ovf       = ovf_q;

endmodule
